// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Two-phase CPU handshake; word-addressed RAM with combinational read.
module dcache #(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        addr_valid,
    output logic        addr_ready,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int SEL_W = INDEX_W + OFFSET_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]         r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [OFFSET_W-1:0] r_cnt;
    logic [31:0]         r_rdata;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES*WORDS];

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_idx;
    logic [OFFSET_W-1:0] w_off;
    logic                w_hit;
    logic                w_last;
    logic [SEL_W-1:0]    w_word_sel;
    logic [SEL_W-1:0]    w_fill_sel;

    assign w_tag      = r_addr[31:SEL_W];
    assign w_idx      = r_addr[SEL_W-1:OFFSET_W];
    assign w_off      = r_addr[OFFSET_W-1:0];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last     = (r_cnt == {OFFSET_W{1'b1}});
    assign w_word_sel = {w_idx, w_off};
    assign w_fill_sel = {w_idx, r_cnt};
    assign rdata      = r_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (addr_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we)       w_next = S_WRITE;
                else if (w_hit) w_next = S_RESP;
                else            w_next = S_REFILL;
            end
            S_REFILL: begin
                if (w_last) w_next = S_RESP;
            end
            S_WRITE: w_next = S_RESP;
            S_RESP: begin
                if (data_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        addr_ready = 1'b0;
        data_valid = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE:   addr_ready = 1'b1;
            S_REFILL: mem_addr = {w_tag, w_idx, r_cnt};
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            S_RESP:   data_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (addr_valid) begin
                        r_addr  <= addr;
                        r_we    <= we;
                        r_wdata <= wdata;
                    end
                end
                S_LOOKUP: begin
                    if (!r_we && w_hit)  r_rdata <= r_data[w_word_sel];
                    if (!r_we && !w_hit) r_cnt   <= '0;
                end
                S_REFILL: begin
                    if (r_cnt == w_off) r_rdata <= mem_rdata;
                    // line becomes valid only once every word has landed
                    if (w_last) r_valid[w_idx] <= 1'b1;
                    else        r_cnt          <= r_cnt + 1'b1;
                end
                S_WRITE: r_rdata <= r_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_REFILL) begin
            r_data[w_fill_sel] <= mem_rdata;
            if (w_last) r_tag[w_idx] <= w_tag;
        end
        if (r_state == S_WRITE && w_hit) begin
            r_data[w_word_sel] <= r_wdata;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Randomized bench for dcache against a line-presence model and shadow RAM.
// Every cycle of every transaction is compared with the expected timeline.
module tb_dcache;
    logic        clk = 1'b0;
    logic        rstn;
    logic        addr_valid;
    logic        addr_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [1024];
    logic [31:0] sh  [1024];
    bit          mvalid [16];
    logic [25:0] mtag   [16];

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    dcache dut (
        .clk        (clk),
        .rstn       (rstn),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ctrl(input string nm, input bit ar, input bit dv,
                            input bit mw, input logic [31:0] ma,
                            input logic [31:0] md);
        chk({nm, " addr_ready"}, 32'(addr_ready), 32'(ar));
        chk({nm, " data_valid"}, 32'(data_valid), 32'(dv));
        chk({nm, " mem_we"},     32'(mem_we),     32'(mw));
        chk({nm, " mem_addr"},   mem_addr,        ma);
        chk({nm, " mem_wdata"},  mem_wdata,       md);
    endtask

    // Entered #1 after a rising edge with the cache idle.
    task automatic do_op(input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int hold);
        logic [25:0] t   = a[31:6];
        int          idx = int'(a[5:2]);
        bit          hit = mvalid[idx] && (mtag[idx] == t);
        logic [31:0] exp = w ? d : sh[a[9:0]];
        int          lat = w ? 3 : (hit ? 2 : 6);
        addr_valid = 1'b1;
        we         = w;
        addr       = a;
        wdata      = d;
        data_ready = 1'b0;
        @(negedge clk);
        chk_ctrl("accept", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        addr_valid = 1'($urandom);
        we         = 1'($urandom);
        addr       = $urandom;
        wdata      = $urandom;
        for (int k = 1; k < lat; k++) begin
            logic [31:0] ea = 32'h0;
            logic [31:0] ed = 32'h0;
            bit          ew = 1'b0;
            if (!w && !hit && k >= 2) ea = {a[31:2], 2'(k - 2)};
            if (w && k == 2) begin
                ew = 1'b1;
                ea = a;
                ed = d;
            end
            @(negedge clk);
            chk_ctrl($sformatf("busy k%0d", k), 1'b0, 1'b0, ew, ea, ed);
            @(posedge clk);
            #1;
            addr_valid = 1'($urandom);
            addr       = $urandom;
            wdata      = $urandom;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk_ctrl("resp", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            chk("rdata", rdata, exp);
            last_rdata = rdata;
            if (h == hold) begin
                data_ready = 1'b1;
                addr_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            data_ready = 1'b0;
        end
        if (w) begin
            sh[a[9:0]] = d;
        end else if (!hit) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = t;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = {16'hC0DE, 16'(i)};
            sh[i]  = {16'hC0DE, 16'(i)};
        end
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
        rstn       = 1'b0;
        addr_valid = 1'b0;
        we         = 1'b0;
        addr       = 32'h0;
        wdata      = 32'h0;
        data_ready = 1'b0;
        #12;
        chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        do_op(1'b0, 32'h10, 32'h0, 0);
        chk("t1 lit", last_rdata, 32'hC0DE0010);
        do_op(1'b0, 32'h12, 32'h0, 0);
        chk("t2 lit", last_rdata, 32'hC0DE0012);
        do_op(1'b1, 32'h11, 32'hDEAD, 0);
        do_op(1'b0, 32'h11, 32'h0, 0);
        chk("t3 lit", last_rdata, 32'h0000DEAD);
        do_op(1'b1, 32'h50, 32'h1234, 1);
        do_op(1'b0, 32'h50, 32'h0, 0);
        chk("t4 lit", last_rdata, 32'h00001234);
        do_op(1'b0, 32'h110, 32'h0, 0);
        chk("t5a lit", last_rdata, 32'hC0DE0110);
        do_op(1'b0, 32'h10, 32'h0, 0);
        chk("t5b lit", last_rdata, 32'hC0DE0010);
        do_op(1'b0, 32'h13, 32'h0, 5);
        chk("t6 lit", last_rdata, 32'hC0DE0013);
        do_op(1'b0, 32'h3F, 32'h0, 0);
        chk("edge lit", last_rdata, 32'hC0DE003F);

        // Abort a refill of line 9 part way through.
        addr_valid = 1'b1;
        we         = 1'b0;
        addr       = 32'h24;
        @(posedge clk);
        #1;
        addr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_ctrl("midrst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        chk_ctrl("midrst hold", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        do_op(1'b0, 32'h24, 32'h0, 0);
        chk("after rst lit", last_rdata, 32'hC0DE0024);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {23'd0, 3'($urandom_range(0, 7)), 4'($urandom), 2'($urandom)};
            do_op($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
